// File: rtl/uart_rx_deser_if.sv
// Byte-side and serial-side signals of the UART receiver, grouped for the FIFO/control hookup.
interface uart_rx_deser_if;
    logic       rx;
    logic       full;
    logic       clr;
    logic [7:0] rdata;
    logic       wr;
    logic       ferr;
    logic       ovr;
    logic       busy;

    modport master (output rx, full, clr, input rdata, wr, ferr, ovr, busy);
    modport slave  (input rx, full, clr, output rdata, wr, ferr, ovr, busy);
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizes rx, recovers frames with a mid-bit down-counter
// and pushes good bytes into the downstream FIFO with a one-cycle wr strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rs = 0
// START     | half-bit wait, confirm start bit is still low
// DATA      | sample 8 data bits, LSB first, one per bit period
// STOP      | sample stop bit; good -> write byte, low -> framing error
// WAIT_IDLE | break/framing recovery, wait for line to return high
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    uart_rx_deser_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   wr_q, wr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   tc;

    assign rs = sync_q[SYNC_STAGES-1];
    assign tc = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        wr_d    = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q & ~bus.clr;
        case (state_q)
            IDLE: begin
                if (!rs) begin
                    state_d = START;
                    cnt_d   = HALF_LD;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tc) begin
                    if (rs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = BIT_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tc) begin
                    shift_d = {rs, shift_q[7:1]};
                    cnt_d   = BIT_LD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tc) begin
                    if (rs) begin
                        state_d = IDLE;
                        rdata_d = shift_q;
                        // overrun set wins over a simultaneous clr
                        if (bus.full) begin
                            ovr_d = 1'b1;
                        end else begin
                            wr_d = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.wr    = wr_q;
    assign bus.ferr  = ferr_q;
    assign bus.ovr   = ovr_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: frames queue expected bytes/cycles, a monitor checks wr and ferr pulses.
module tb_uart_rx_deser;
    localparam int N   = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + N/2 + 9*N + 1;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t wr_q[$];
    int   ferr_q[$];

    uart_rx_deser_if bus ();

    uart_rx_deser #(.CLKS_PER_BIT(N), .SYNC_STAGES(SS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 = expect wr, 1 = expect ferr, 2 = expect nothing
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int kind);
        logic [9:0] f;
        exp_t       e;
        int         t0;
        f  = {stop_bit, d, 1'b0};
        t0 = cyc;
        if (kind == 0) begin
            e.d   = d;
            e.cyc = t0 + LAT;
            wr_q.push_back(e);
        end else if (kind == 1) begin
            ferr_q.push_back(t0 + LAT);
        end
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            idle(N);
        end
    endtask

    initial begin
        exp_t e;
        int   fc;
        forever begin
            @(negedge clk);
            if (bus.wr) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got wr=1 rdata=%h at cycle %0d expected no wr", bus.rdata, cyc);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_rdata", bus.rdata, e.d);
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL wr_cycle: got %0d expected %0d", cyc, e.cyc);
                    end
                end
            end
            if (bus.ferr) begin
                checks++;
                if (ferr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ferr_unexpected: got ferr=1 at cycle %0d expected no ferr", cyc);
                end else begin
                    fc = ferr_q.pop_front();
                    if (cyc != fc) begin
                        errors++;
                        $display("FAIL ferr_cycle: got %0d expected %0d", cyc, fc);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.full = 1'b0;
        bus.clr = 1'b0;
        idle(3);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_wr", {7'd0, bus.wr}, 8'h00);
        check("rst_ferr", {7'd0, bus.ferr}, 8'h00);
        check("rst_ovr", {7'd0, bus.ovr}, 8'h00);
        check("rst_busy", {7'd0, bus.busy}, 8'h00);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, 0);
        idle(20);
        check("a5_rdata_hold", bus.rdata, 8'hA5);
        check("a5_ferr", {7'd0, bus.ferr}, 8'h00);
        check("a5_ovr", {7'd0, bus.ovr}, 8'h00);
        check("a5_busy", {7'd0, bus.busy}, 8'h00);

        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(20);

        send_frame(8'h5A, 1'b0, 1);
        idle(40);
        check("brk_busy", {7'd0, bus.busy}, 8'h01);
        check("brk_rdata", bus.rdata, 8'hFF);
        bus.rx = 1'b1;
        idle(5);
        check("brk_busy_rel", {7'd0, bus.busy}, 8'h00);
        send_frame(8'h81, 1'b1, 0);
        idle(20);

        bus.rx = 1'b0;
        idle(4);
        bus.rx = 1'b1;
        idle(2);
        check("glitch_busy_hi", {7'd0, bus.busy}, 8'h01);
        idle(10);
        check("glitch_busy_lo", {7'd0, bus.busy}, 8'h00);
        check("glitch_rdata", bus.rdata, 8'h81);
        idle(10);

        bus.full = 1'b1;
        send_frame(8'h77, 1'b1, 2);
        bus.full = 1'b0;
        idle(10);
        check("ovr_rdata", bus.rdata, 8'h77);
        check("ovr_set", {7'd0, bus.ovr}, 8'h01);
        idle(20);
        check("ovr_sticky", {7'd0, bus.ovr}, 8'h01);
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        check("ovr_clr", {7'd0, bus.ovr}, 8'h00);
        idle(10);

        bus.full = 1'b1;
        fork
            send_frame(8'h66, 1'b1, 2);
            begin
                idle(LAT - 1);
                bus.clr = 1'b1;
                idle(1);
                bus.clr = 1'b0;
            end
        join
        bus.full = 1'b0;
        idle(5);
        check("ovr_prio", {7'd0, bus.ovr}, 8'h01);
        check("ovr2_rdata", bus.rdata, 8'h66);

        d = 8'hC3;
        bus.rx = 1'b0;
        idle(N);
        for (int i = 0; i < 4; i++) begin
            bus.rx = d[i];
            idle(N);
        end
        bus.rx = d[4];
        idle(N/2);
        rst = 1'b1;
        idle(1);
        check("mid_rst_rdata", bus.rdata, 8'h00);
        check("mid_rst_wr", {7'd0, bus.wr}, 8'h00);
        check("mid_rst_ferr", {7'd0, bus.ferr}, 8'h00);
        check("mid_rst_ovr", {7'd0, bus.ovr}, 8'h00);
        check("mid_rst_busy", {7'd0, bus.busy}, 8'h00);
        rst = 1'b0;
        bus.rx = 1'b1;
        idle(200);
        send_frame(8'h12, 1'b1, 0);
        idle(30);
        check("post_rst_rdata", bus.rdata, 8'h12);

        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL wr_missing: got %0d pending expected 0", wr_q.size());
        end
        checks++;
        if (ferr_q.size() != 0) begin
            errors++;
            $display("FAIL ferr_missing: got %0d pending expected 0", ferr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
